regfile_mp: RTL and testbench

- Parametrised multi-port general-purpose register file; successor to the fixed 2-read/1-write 32x32 register file.
- Sits between the ID stage (read ports) and the WB stage (write ports). Supports dual-issue or extra-operand configurations.
- Adds a post-reset clear sequencer so storage is deterministic zero without a wide reset fan-out.
- Adds multi-write priority and a busy status output.

---
 rtl/regfile_mp_pkg.sv | 19 +
 rtl/regfile_rd_port.sv | 53 +++++
 rtl/regfile_mp.sv | 98 +++++++++
 tb/tb_regfile_mp.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared constants and clear-FSM encoding for the multi-port register file.
// Default widths match the RegBus/RegAddrBus buses used by the pipeline.
package regfile_mp_pkg;

    localparam logic RST_ACTIVE = 1'b1;
    localparam logic WE_ACTIVE  = 1'b1;
    localparam logic RE_ACTIVE  = 1'b1;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_W-1:0] ZERO_WORD = '0;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: masking, zero register, write-port bypass,
// then the stored word, in that priority order.
module regfile_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = REG_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_WR   = 1,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     rst,
    input  logic                     busy,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        raddr,
    input  logic [DATA_W-1:0]        stored,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    // Ascending scan so the highest-index matching write port is the one kept.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = DATA_W'(ZERO_WORD);
        for (int j = 0; j < NUM_WR; j++) begin
            if (we[j] == WE_ACTIVE && waddr[j*ADDR_W +: ADDR_W] == raddr) begin
                fwd_hit  = 1'b1;
                fwd_data = wdata[j*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rdata = DATA_W'(ZERO_WORD);
        if (rst == RST_ACTIVE || busy) begin
            rdata = DATA_W'(ZERO_WORD);
        end else if (re != RE_ACTIVE) begin
            rdata = DATA_W'(ZERO_WORD);
        end else if (ZERO_REG && raddr == '0) begin
            rdata = DATA_W'(ZERO_WORD);
        end else if (BYPASS && fwd_hit) begin
            rdata = fwd_data;
        end else begin
            rdata = stored;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with a post-reset clear sequencer
// that zeroes storage one word per cycle instead of resetting every bit.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = REG_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    output logic                     busy
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = '1;

    logic [DATA_W-1:0] storage [DEPTH];
    clr_state_e        state_reg;
    logic [ADDR_W-1:0] clr_ptr_reg;
    logic              busy_int;
    logic [NUM_WR-1:0] wr_ok;

    assign busy_int = (rst == RST_ACTIVE) || (state_reg == CLEAR);
    assign busy     = busy_int;

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            state_reg   <= CLEAR;
            clr_ptr_reg <= '0;
        end else if (state_reg == CLEAR) begin
            clr_ptr_reg <= clr_ptr_reg + 1'b1;
            if (clr_ptr_reg == LAST_PTR) begin
                state_reg <= READY;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
            assign wr_ok[gi] = (we[gi] == WE_ACTIVE) &&
                               !(ZERO_REG && waddr[gi*ADDR_W +: ADDR_W] == '0);
        end
    endgenerate

    // Later loop iterations override earlier ones, giving the higher port priority.
    always_ff @(posedge clk) begin
        if (rst != RST_ACTIVE) begin
            if (state_reg == CLEAR) begin
                storage[clr_ptr_reg] <= DATA_W'(ZERO_WORD);
            end else begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_ok[j]) begin
                        storage[waddr[j*ADDR_W +: ADDR_W]] <= wdata[j*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] rd_addr;
            logic [DATA_W-1:0] rd_stored;
            assign rd_addr   = raddr[gi*ADDR_W +: ADDR_W];
            assign rd_stored = storage[rd_addr];

            regfile_rd_port #(
                .DATA_W  (DATA_W),
                .ADDR_W  (ADDR_W),
                .NUM_WR  (NUM_WR),
                .ZERO_REG(ZERO_REG),
                .BYPASS  (BYPASS)
            ) u_rd_port (
                .rst   (rst),
                .busy  (busy_int),
                .re    (re[gi]),
                .raddr (rd_addr),
                .stored(rd_stored),
                .we    (we),
                .waddr (waddr),
                .wdata (wdata),
                .rdata (rdata[gi*DATA_W +: DATA_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a dual-write bypassing instance and a single-write,
// non-bypassing, ordinary-r0 instance driven from the same stimulus.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [63:0] rdata_alt;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        busy;
    logic        busy_alt;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q [$];

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .re(re), .raddr(raddr), .rdata(rdata),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy)
    );

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(1'b0), .BYPASS(1'b0)
    ) dut_alt (
        .clk(clk), .rst(rst), .re(re), .raddr(raddr), .rdata(rdata_alt),
        .we(we[0]), .waddr(waddr[4:0]), .wdata(wdata[31:0]), .busy(busy_alt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected words are queued in order: main p0, main p1, alt p0, alt p1.
    task automatic push4(input logic [31:0] m0, input logic [31:0] m1,
                         input logic [31:0] a0, input logic [31:0] a1);
        exp_q.push_back(m0);
        exp_q.push_back(m1);
        exp_q.push_back(a0);
        exp_q.push_back(a1);
    endtask

    // Pulses rst for one edge, optionally disturbs the clear, counts busy cycles.
    task automatic pulse_rst_and_clear(input int inject_at, input bit inject_rst,
                                       output int cycles);
        @(negedge clk);
        rst = 1'b1;
        we  = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        cycles = 0;
        while ((busy || busy_alt) && cycles < 200) begin
            cycles++;
            if (cycles == inject_at) begin
                if (inject_rst) begin
                    rst = 1'b1;
                end else begin
                    we    = 2'b01;
                    waddr = {5'd0, 5'd3};
                    wdata = {32'h0, 32'h1};
                end
            end
            @(negedge clk);
            rst = 1'b0;
            we  = 2'b00;
            #1;
        end
    endtask

    task automatic test_reset();
        logic [127:0] obs;
        logic [31:0]  exp;
        int           cyc;
        @(negedge clk);
        rst = 1'b1; re = 2'b11; raddr = {5'd9, 5'd1};
        push4(32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        obs = {rdata_alt, rdata};
        for (int k = 0; k < 4; k++) begin
            exp = exp_q.pop_front();
            checks++;
            if (obs[k*32 +: 32] !== exp) begin
                errors++;
                $display("FAIL rdata_in_rst word%0d: got %h expected %h", k, obs[k*32 +: 32], exp);
            end
        end
        checks++;
        if (busy !== 1'b1 || busy_alt !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_rst: got %b/%b expected 1/1", busy, busy_alt);
        end
        pulse_rst_and_clear(10, 1'b0, cyc);
        checks++;
        if (cyc !== 32) begin
            errors++;
            $display("FAIL clear_length: got %0d expected 32", cyc);
        end
        $display("reset: busy cycles=%0d", cyc);
    endtask

    task automatic test_clear_zero();
        logic [127:0] obs;
        logic [31:0]  exp;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            re = 2'b11; we = 2'b00;
            raddr = {5'(31 - a), 5'(a)};
            push4(32'h0, 32'h0, 32'h0, 32'h0);
            #1;
            obs = {rdata_alt, rdata};
            for (int k = 0; k < 4; k++) begin
                exp = exp_q.pop_front();
                checks++;
                if (obs[k*32 +: 32] !== exp) begin
                    errors++;
                    $display("FAIL clear_zero addr%0d word%0d: got %h expected %h", a, k, obs[k*32 +: 32], exp);
                end
            end
        end
        $display("clear_zero: read all 32 addresses");
    endtask

    task automatic test_write_readback();
        logic [127:0] obs;
        logic [31:0]  exp;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            re = 2'b11; raddr = {5'd5, 5'd5};
            if (c == 0) begin
                we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF};
                push4(32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0);
            end else begin
                we = 2'b00;
                push4(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
            end
            #1;
            obs = {rdata_alt, rdata};
            for (int k = 0; k < 4; k++) begin
                exp = exp_q.pop_front();
                checks++;
                if (obs[k*32 +: 32] !== exp) begin
                    errors++;
                    $display("FAIL write_readback cyc%0d word%0d: got %h expected %h", c, k, obs[k*32 +: 32], exp);
                end
            end
            $display("write_readback cyc%0d: main p1=%h alt p1=%h", c, rdata[63:32], rdata_alt[63:32]);
        end
    endtask

    task automatic test_zero_reg();
        logic [127:0] obs;
        logic [31:0]  exp;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            re = 2'b11; raddr = {5'd0, 5'd0};
            if (c == 0) begin
                we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'h12345678};
                push4(32'h0, 32'h0, 32'h0, 32'h0);
            end else begin
                we = 2'b00;
                push4(32'h0, 32'h0, 32'h12345678, 32'h12345678);
            end
            #1;
            obs = {rdata_alt, rdata};
            for (int k = 0; k < 4; k++) begin
                exp = exp_q.pop_front();
                checks++;
                if (obs[k*32 +: 32] !== exp) begin
                    errors++;
                    $display("FAIL zero_reg cyc%0d word%0d: got %h expected %h", c, k, obs[k*32 +: 32], exp);
                end
            end
            $display("zero_reg cyc%0d: main r0=%h alt r0=%h", c, rdata[31:0], rdata_alt[31:0]);
        end
    endtask

    task automatic test_dual_write();
        logic [127:0] obs;
        logic [31:0]  exp;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            re = 2'b11; raddr = {5'd7, 5'd7};
            if (c == 0) begin
                we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h5555FFFF, 32'hAAAA0000};
                push4(32'h5555FFFF, 32'h5555FFFF, 32'h0, 32'h0);
            end else begin
                we = 2'b00;
                push4(32'h5555FFFF, 32'h5555FFFF, 32'hAAAA0000, 32'hAAAA0000);
            end
            #1;
            obs = {rdata_alt, rdata};
            for (int k = 0; k < 4; k++) begin
                exp = exp_q.pop_front();
                checks++;
                if (obs[k*32 +: 32] !== exp) begin
                    errors++;
                    $display("FAIL dual_write cyc%0d word%0d: got %h expected %h", c, k, obs[k*32 +: 32], exp);
                end
            end
            $display("dual_write cyc%0d: main r7=%h", c, rdata[31:0]);
        end
    endtask

    task automatic test_read_enable();
        logic [127:0] obs;
        logic [31:0]  exp;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            raddr = {5'd3, 5'd3};
            case (c)
                0: begin
                    re = 2'b11; we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h33};
                    push4(32'h33, 32'h33, 32'h0, 32'h0);
                end
                1: begin
                    re = 2'b01; we = 2'b00;
                    push4(32'h33, 32'h0, 32'h33, 32'h0);
                end
                default: begin
                    re = 2'b00; we = 2'b00;
                    push4(32'h0, 32'h0, 32'h0, 32'h0);
                end
            endcase
            #1;
            obs = {rdata_alt, rdata};
            for (int k = 0; k < 4; k++) begin
                exp = exp_q.pop_front();
                checks++;
                if (obs[k*32 +: 32] !== exp) begin
                    errors++;
                    $display("FAIL read_enable cyc%0d word%0d: got %h expected %h", c, k, obs[k*32 +: 32], exp);
                end
            end
            $display("read_enable cyc%0d: re=%b main=%h/%h", c, re, rdata[31:0], rdata[63:32]);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [127:0] obs;
        logic [31:0]  exp;
        int           cyc;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin
                pulse_rst_and_clear(20, 1'b1, cyc);
                checks++;
                if (cyc !== 52) begin
                    errors++;
                    $display("FAIL mid_clear_length: got %0d expected 52", cyc);
                end
                $display("reset_mid_clear: busy cycles=%0d", cyc);
            end
            @(negedge clk);
            re = 2'b11; raddr = (c == 3) ? {5'd5, 5'd7} : {5'd9, 5'd9};
            if (c == 0) begin
                we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'hFF};
                push4(32'hFF, 32'hFF, 32'h0, 32'h0);
            end else if (c == 1) begin
                we = 2'b00;
                push4(32'hFF, 32'hFF, 32'hFF, 32'hFF);
            end else begin
                we = 2'b00;
                push4(32'h0, 32'h0, 32'h0, 32'h0);
            end
            #1;
            obs = {rdata_alt, rdata};
            for (int k = 0; k < 4; k++) begin
                exp = exp_q.pop_front();
                checks++;
                if (obs[k*32 +: 32] !== exp) begin
                    errors++;
                    $display("FAIL reset_mid_clear cyc%0d word%0d: got %h expected %h", c, k, obs[k*32 +: 32], exp);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; re = 2'b00; raddr = '0; we = 2'b00; waddr = '0; wdata = '0;
        test_reset();
        test_clear_zero();
        test_write_readback();
        test_zero_reg();
        test_dual_write();
        test_read_enable();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
